// File: rtl/mem_responder.sv
// mem_responder: responder side of the core's doubleword memory interface.
// Two registered read ports (fetch, load) and one posted store port. Stores
// enter a FIFO write buffer that drains into the storage array whenever a
// read leaves an array port free. Reads forward from the buffer, taking the
// youngest matching entry, so posted stores are visible one cycle after
// acceptance.
//
// Ports:
//   clk, rstN                    clock, async active-low reset
//   readEn0/readAddr0            fetch read request
//   readData0/readValid0         fetch read response, one cycle later
//   readEn1/readAddr1            load read request
//   readData1/readValid1         load read response, one cycle later
//   writeEn/writeAddr/writeData  store request
//   writeReady                   buffer not full (from registered count)
//   overflow                     sticky: store offered while not ready
//   bufCount                     occupied buffer entries
module mem_responder #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned WBUF_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          readEn0,
    input  logic [0:60]                   readAddr0,
    output logic [0:63]                   readData0,
    output logic                          readValid0,
    input  logic                          readEn1,
    input  logic [0:60]                   readAddr1,
    output logic [0:63]                   readData1,
    output logic                          readValid1,
    input  logic                          writeEn,
    input  logic [0:60]                   writeAddr,
    input  logic [0:63]                   writeData,
    output logic                          writeReady,
    output logic                          overflow,
    output logic [$clog2(WBUF_DEPTH):0]   bufCount
);

    localparam int unsigned PTR_W       = $clog2(WBUF_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;
    localparam int unsigned IDX_LO      = 61 - ADDR_BITS;
    localparam int unsigned ARRAY_DEPTH = 2 ** ADDR_BITS;

    // Storage array and write-buffer payload (neither is reset).
    logic [0:63]          mem_q     [ARRAY_DEPTH];
    logic [ADDR_BITS-1:0] wb_addr_q [WBUF_DEPTH];
    logic [0:63]          wb_data_q [WBUF_DEPTH];

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic                 valid0_q, valid1_q;
    logic [0:63]          data0_q, data1_q;

    logic [ADDR_BITS-1:0] idx0_c, idx1_c, widx_c;
    logic                 hit0_c, hit1_c;
    logic [0:63]          fwd0_c, fwd1_c;
    logic [0:63]          rdata0_c, rdata1_c;
    logic [PTR_W-1:0]     slot_c;
    logic                 ready_c, push_c, drain_c;

    // Only the low ADDR_BITS of each address select an array entry.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{readAddr0[0:IDX_LO-1], readAddr1[0:IDX_LO-1],
                                writeAddr[0:IDX_LO-1]};

    assign idx0_c = readAddr0[IDX_LO:60];
    assign idx1_c = readAddr1[IDX_LO:60];
    assign widx_c = writeAddr[IDX_LO:60];

    // Ready comes from registered occupancy only: no same-cycle pass-through.
    assign ready_c = (count_q != CNT_W'(WBUF_DEPTH));
    assign push_c  = writeEn && ready_c;
    // Reads own both array ports; drain only when one of them is idle.
    assign drain_c = (count_q != '0) && !(readEn0 && readEn1);

    // Buffer search, oldest to youngest so the last hit is the youngest.
    // The head entry is searched even if it drains at this edge.
    always_comb begin
        hit0_c = 1'b0;
        hit1_c = 1'b0;
        fwd0_c = '0;
        fwd1_c = '0;
        slot_c = '0;
        for (int unsigned i = 0; i < WBUF_DEPTH; i++) begin
            slot_c = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if (wb_addr_q[slot_c] == idx0_c) begin
                    hit0_c = 1'b1;
                    fwd0_c = wb_data_q[slot_c];
                end
                if (wb_addr_q[slot_c] == idx1_c) begin
                    hit1_c = 1'b1;
                    fwd1_c = wb_data_q[slot_c];
                end
            end
        end
    end

    assign rdata0_c = hit0_c ? fwd0_c : mem_q[idx0_c];
    assign rdata1_c = hit1_c ? fwd1_c : mem_q[idx1_c];

    // Next buffer state.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q | (writeEn & ~ready_c);
        if (push_c) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (drain_c) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({push_c, drain_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer control registers; pending entries are discarded on reset.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer payload write. A push seen during reset is harmless: count stays 0.
    always_ff @(posedge clk) begin
        if (push_c) begin
            wb_addr_q[tail_q] <= widx_c;
            wb_data_q[tail_q] <= writeData;
        end
    end

    // Array write port: head entry drains. Count is 0 in reset, so no drain.
    always_ff @(posedge clk) begin
        if (drain_c) begin
            mem_q[wb_addr_q[head_q]] <= wb_data_q[head_q];
        end
    end

    // Registered read responses; data holds while no request.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            data0_q  <= '0;
            data1_q  <= '0;
        end else begin
            valid0_q <= readEn0;
            valid1_q <= readEn1;
            if (readEn0) begin
                data0_q <= rdata0_c;
            end
            if (readEn1) begin
                data1_q <= rdata1_c;
            end
        end
    end

    assign readData0  = data0_q;
    assign readValid0 = valid0_q;
    assign readData1  = data1_q;
    assign readValid1 = valid1_q;
    assign writeReady = ready_c;
    assign overflow   = overflow_q;
    assign bufCount   = count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_mem_responder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned NADDR  = 16;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        readEn0 = 1'b0, readEn1 = 1'b0, writeEn = 1'b0;
    logic [0:60] readAddr0 = '0, readAddr1 = '0, writeAddr = '0;
    logic [0:63] writeData = '0;
    logic [0:63] readData0, readData1;
    logic        readValid0, readValid1, writeReady, overflow;
    logic [2:0]  bufCount;

    mem_responder #(.ADDR_BITS(10), .WBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rstN(rstN),
        .readEn0(readEn0), .readAddr0(readAddr0), .readData0(readData0), .readValid0(readValid0),
        .readEn1(readEn1), .readAddr1(readAddr1), .readData1(readData1), .readValid1(readValid1),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .writeReady(writeReady), .overflow(overflow), .bufCount(bufCount)
    );

    always #5 clk = ~clk;

    // Reference model: pending stores in program order, plus the array image.
    typedef struct {
        int unsigned a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] mmem [int unsigned];
    logic        m_ovf;
    logic        m_v0, m_v1;
    logic [63:0] m_d0, m_d1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value a read of array index idx should see right now.
    function automatic logic [63:0] mdl_read(input int unsigned idx);
        logic [63:0] r;
        r = mmem.exists(idx) ? mmem[idx] : 64'h0;
        foreach (mq[i]) if (mq[i].a == idx) r = mq[i].d;
        return r;
    endfunction

    // Full address with random upper bits that must be ignored.
    function automatic logic [60:0] mk_addr(input int unsigned idx);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return {r[50:0], 10'(idx)};
    endfunction

    // One clock: drive inputs, advance model, check every output after the edge.
    task automatic step(input logic re0, input int unsigned i0,
                        input logic re1, input int unsigned i1,
                        input logic we, input int unsigned wi, input logic [63:0] wd);
        logic ready;
        ent_t e;
        readEn0   = re0;  readAddr0 = mk_addr(i0);
        readEn1   = re1;  readAddr1 = mk_addr(i1);
        writeEn   = we;   writeAddr = mk_addr(wi);
        writeData = wd;
        m_v0 = re0;
        m_v1 = re1;
        if (re0) m_d0 = mdl_read(i0);
        if (re1) m_d1 = mdl_read(i1);
        ready = (mq.size() != DEPTH);
        if (we && !ready) m_ovf = 1'b1;
        if (mq.size() > 0 && !(re0 && re1)) begin
            e = mq.pop_front();
            mmem[e.a] = e.d;
        end
        if (we && ready) begin
            e.a = wi;
            e.d = wd;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
        check("readValid0", 64'(readValid0), 64'(m_v0));
        check("readData0",  readData0, m_d0);
        check("readValid1", 64'(readValid1), 64'(m_v1));
        check("readData1",  readData1, m_d1);
        check("bufCount",   64'(bufCount), 64'(mq.size()));
        check("writeReady", 64'(writeReady), 64'(mq.size() != DEPTH));
        check("overflow",   64'(overflow), 64'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 1'b0, 0, 1'b0, 0, 64'h0);
    endtask

    // Async reset mid-cycle; outputs must clear before any clock edge.
    task automatic apply_reset();
        readEn0 = 1'b0; readEn1 = 1'b0; writeEn = 1'b0;
        rstN = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_d0 = '0;   m_d1 = '0;
        check("rst_bufCount",   64'(bufCount), 64'(0));
        check("rst_writeReady", 64'(writeReady), 64'(1));
        check("rst_overflow",   64'(overflow), 64'(0));
        check("rst_readValid0", 64'(readValid0), 64'(0));
        check("rst_readValid1", 64'(readValid1), 64'(0));
        check("rst_readData0",  readData0, 64'h0);
        check("rst_readData1",  readData1, 64'h0);
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        m_ovf = 1'b0;
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_d0 = '0;   m_d1 = '0;
        @(posedge clk);
        #1;
        apply_reset();

        // Give every address used below a known array value of zero.
        for (int unsigned a = 0; a < NADDR; a++) step(1'b0, 0, 1'b0, 0, 1'b1, a, 64'h0);
        idle(2);

        // Store then read back through the array.
        step(1'b0, 0, 1'b0, 0, 1'b1, 5, 64'h1122334455667788);
        idle(1);
        step(1'b1, 5, 1'b0, 0, 1'b0, 0, 64'h0);
        check("t1_data", readData0, 64'h1122334455667788);

        // Reads block drains: fill, overflow, then release one port.
        for (int unsigned a = 0; a < 4; a++)
            step(1'b1, 10, 1'b1, 11, 1'b1, a, 64'h100 + 64'(a));
        check("t2_full", 64'(writeReady), 64'(0));
        step(1'b1, 10, 1'b1, 11, 1'b1, 4, 64'hBAD);
        check("t2_ovf", 64'(overflow), 64'(1));
        check("t2_cnt", 64'(bufCount), 64'(4));
        for (int k = 0; k < 5; k++) step(1'b1, k, 1'b0, 0, 1'b0, 0, 64'h0);
        step(1'b1, 4, 1'b0, 0, 1'b0, 0, 64'h0);
        check("t2_dropped", readData0, 64'h0);

        // Youngest buffered store wins.
        step(1'b1, 1, 1'b1, 2, 1'b1, 7, 64'hA);
        step(1'b1, 1, 1'b1, 2, 1'b1, 7, 64'hB);
        step(1'b1, 7, 1'b1, 7, 1'b0, 0, 64'h0);
        check("t3_fwd", readData0, 64'hB);
        idle(3);
        step(1'b1, 7, 1'b0, 0, 1'b0, 0, 64'h0);
        check("t3_array", readData0, 64'hB);

        // Same-cycle store and read returns the old value.
        step(1'b1, 9, 1'b0, 0, 1'b1, 9, 64'hDEAD);
        check("t4_old", readData0, 64'h0);
        step(1'b1, 9, 1'b0, 0, 1'b0, 0, 64'h0);
        check("t4_new", readData0, 64'hDEAD);

        // Both ports hit the same buffered address.
        step(1'b1, 0, 1'b1, 1, 1'b1, 3, 64'h3333);
        step(1'b1, 3, 1'b1, 3, 1'b0, 0, 64'h0);
        check("t5_d0", readData0, 64'h3333);
        check("t5_d1", readData1, 64'h3333);

        // Reset with three pending entries; drained data survives.
        idle(3);
        for (int unsigned a = 12; a < 15; a++)
            step(1'b1, 0, 1'b1, 0, 1'b1, a, 64'hF00 + 64'(a));
        check("t6_cnt", 64'(bufCount), 64'(3));
        apply_reset();
        step(1'b1, 5, 1'b1, 12, 1'b0, 0, 64'h0);
        check("t6_kept", readData0, 64'h1122334455667788);
        check("t6_discard", readData1, 64'h0);

        // Random traffic, biased toward blocked drains to fill the buffer.
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 9) < 7), $urandom_range(0, NADDR - 1),
                 1'($urandom_range(0, 9) < 7), $urandom_range(0, NADDR - 1),
                 1'($urandom_range(0, 1)), $urandom_range(0, NADDR - 1),
                 {$urandom(), $urandom()});
        idle(DEPTH + 1);
        for (int unsigned a = 0; a < NADDR; a++)
            step(1'b1, a, 1'b1, NADDR - 1 - a, 1'b0, 0, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
